// File: rtl/seu_err_collector.sv
// -----------------------------------------------------------------------------
// seu_err_collector
//
// Collects the level-type error lines of the single-bit-flip parity detectors
// and turns them into software-visible status:
//   - per-source sticky flags
//   - a saturating event counter with a lost-event (overflow) flag
//   - capture of the source that raised the alarm
//   - a level interrupt that is high while the block is in ALARM
// An "event" is a rising edge of a source's error line while that source is
// unmasked. All status is held until a single-cycle clear pulse.
//
// Ports:
//   clk_i         rising-edge clock
//   rstn_i        asynchronous active-low reset, clears all state
//   err_i         raw error levels, bit k = detector k
//   mask_i        1 = ignore source k (no event, no sticky, no count)
//   clr_i         single-cycle clear request
//   sticky_o      per-source latched error flags
//   count_o       total detected events, saturating at all-ones
//   overflow_o    counter saturated and at least one further event was lost
//   first_src_o   index of the source that moved IDLE -> ALARM
//   first_valid_o first_src_o is meaningful
//   irq_o         interrupt level, high while in ALARM
// All outputs are registered.
// -----------------------------------------------------------------------------
module seu_err_collector #(
  parameter  int N_SRC = 8,
  parameter  int CNT_W = 16,
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_SRC-1:0] err_i,
  input  logic [N_SRC-1:0] mask_i,
  input  logic             clr_i,
  output logic [N_SRC-1:0] sticky_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic [IDX_W-1:0] first_src_o,
  output logic             first_valid_o,
  output logic             irq_o
);

  // Six extra bits hold any popcount of up to 32 sources, so the sum can
  // never wrap before the saturation compare.
  localparam int SUM_W = CNT_W + 6;
  localparam logic [SUM_W-1:0] CNT_MAX = {6'b0, {CNT_W{1'b1}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] err_q;
  logic [N_SRC-1:0] ev;
  logic             ev_any;
  logic [5:0]       ev_cnt;
  logic [IDX_W-1:0] ev_low;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_next;
  logic [N_SRC-1:0] sticky_base;

  // Rising-edge detect per source. err_q follows the raw line regardless of
  // the mask, so unmasking a source whose line is already high is not an edge.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_edge
      assign ev[gi] = err_i[gi] & ~err_q[gi] & ~mask_i[gi];
    end
  endgenerate

  assign ev_any = |ev;

  // Number of simultaneous events this cycle.
  always_comb begin
    ev_cnt = '0;
    for (int k = 0; k < N_SRC; k++) begin
      ev_cnt = ev_cnt + {5'b0, ev[k]};
    end
  end

  // Lowest set index of ev: scan downward so the lowest hit wins.
  always_comb begin
    ev_low = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (ev[k]) begin
        ev_low = IDX_W'(k);
      end
    end
  end

  // A clear acts on the old value first; same-cycle events are added on top,
  // so an event is never lost to a clear.
  assign cnt_base    = clr_i ? '0 : count_o;
  assign sticky_base = clr_i ? '0 : sticky_o;
  assign cnt_sum     = {6'b0, cnt_base} + {{CNT_W{1'b0}}, ev_cnt};
  assign cnt_sat     = (cnt_sum > CNT_MAX);
  assign cnt_next    = cnt_sat ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      err_q         <= '0;
      sticky_o      <= '0;
      count_o       <= '0;
      overflow_o    <= 1'b0;
      first_src_o   <= '0;
      first_valid_o <= 1'b0;
      irq_o         <= 1'b0;
    end else begin
      err_q      <= err_i;
      sticky_o   <= sticky_base | ev;
      count_o    <= cnt_next;
      // An overflow in the clearing cycle itself keeps the flag set.
      overflow_o <= (clr_i ? 1'b0 : overflow_o) | cnt_sat;

      case (state)
        IDLE: begin
          if (ev_any) begin
            state         <= ALARM;
            first_src_o   <= ev_low;
            first_valid_o <= 1'b1;
            irq_o         <= 1'b1;
          end
        end
        ALARM: begin
          if (clr_i) begin
            if (ev_any) begin
              // Clear and new event together: stay alarmed, re-capture.
              first_src_o <= ev_low;
            end else begin
              state         <= IDLE;
              first_src_o   <= '0;
              first_valid_o <= 1'b0;
              irq_o         <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seu_err_collector.sv
module tb_seu_err_collector;

  logic       clk;
  logic       rstn;
  logic [7:0] err;
  logic [7:0] mask;
  logic       clr;

  logic [7:0]  a_sticky, b_sticky;
  logic [15:0] a_count;
  logic [1:0]  b_count;
  logic        a_ovf, b_ovf;
  logic [2:0]  a_first, b_first;
  logic        a_valid, b_valid;
  logic        a_irq, b_irq;

  int n_checks = 0;
  int n_errors = 0;

  seu_err_collector #(.N_SRC(8), .CNT_W(16)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .err_i(err), .mask_i(mask), .clr_i(clr),
    .sticky_o(a_sticky), .count_o(a_count), .overflow_o(a_ovf),
    .first_src_o(a_first), .first_valid_o(a_valid), .irq_o(a_irq)
  );

  seu_err_collector #(.N_SRC(8), .CNT_W(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .err_i(err), .mask_i(mask), .clr_i(clr),
    .sticky_o(b_sticky), .count_o(b_count), .overflow_o(b_ovf),
    .first_src_o(b_first), .first_valid_o(b_valid), .irq_o(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vector table (checked against instance A, CNT_W=16)
  typedef struct {
    logic [7:0] err;
    logic [7:0] mask;
    logic       clr;
    logic [7:0] st;
    int         cnt;
    int         first;
    logic       valid;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] e, input logic [7:0] m, input logic c,
                     input logic [7:0] s, input int n, input int f,
                     input logic v, input logic i);
    vec_t x;
    x.err = e; x.mask = m; x.clr = c; x.st = s;
    x.cnt = n; x.first = f; x.valid = v; x.irq = i;
    tbl.push_back(x);
  endtask

  // Behavioural reference model: per-source booleans and integer counters.
  bit prev[8];
  bit m_st[8];
  int m_cnt_a, m_cnt_b;
  bit m_ovf_a, m_ovf_b;
  bit m_alarm;
  int m_first;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      prev[k] = 0;
      m_st[k] = 0;
    end
    m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
    m_alarm = 0; m_first = 0;
  endtask

  task automatic model_step(input logic [7:0] e, input logic [7:0] m, input logic c);
    int n;
    int low;
    int sum;
    bit evk;
    n = 0;
    low = -1;
    for (int k = 0; k < 8; k++) begin
      evk = e[k] && !prev[k] && !m[k];
      if (c) m_st[k] = 0;
      if (evk) begin
        m_st[k] = 1;
        n++;
        if (low < 0) low = k;
      end
      prev[k] = e[k];
    end
    sum = (c ? 0 : m_cnt_a) + n;
    m_ovf_a = (c ? 1'b0 : m_ovf_a) || (sum > 65535);
    m_cnt_a = (sum > 65535) ? 65535 : sum;
    sum = (c ? 0 : m_cnt_b) + n;
    m_ovf_b = (c ? 1'b0 : m_ovf_b) || (sum > 3);
    m_cnt_b = (sum > 3) ? 3 : sum;
    if (!m_alarm) begin
      if (n > 0) begin
        m_alarm = 1;
        m_first = low;
      end
    end else if (c) begin
      if (n == 0) begin
        m_alarm = 0;
        m_first = 0;
      end else begin
        m_first = low;
      end
    end
  endtask

  function automatic logic [7:0] model_sticky();
    logic [7:0] s;
    for (int k = 0; k < 8; k++) s[k] = m_st[k];
    return s;
  endfunction

  task automatic do_reset();
    rstn = 1'b0; err = '0; mask = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; err = '0; mask = '0; clr = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 10; i++) add(8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(8'h08, 8'h00, 0, 8'h08, 1, 3, 1, 1);
    for (int i = 0; i < 4; i++) add(8'h08, 8'h00, 0, 8'h08, 1, 3, 1, 1);
    add(8'h00, 8'h00, 0, 8'h08, 1, 3, 1, 1);
    add(8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    add(8'h24, 8'h00, 0, 8'h24, 2, 2, 1, 1);
    add(8'h00, 8'h00, 0, 8'h24, 2, 2, 1, 1);
    add(8'h01, 8'h00, 0, 8'h25, 3, 2, 1, 1);
    add(8'h00, 8'h00, 0, 8'h25, 3, 2, 1, 1);
    add(8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    add(8'h08, 8'h00, 0, 8'h08, 1, 3, 1, 1);
    add(8'h20, 8'h00, 1, 8'h20, 1, 5, 1, 1);
    add(8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 0);
    add(8'h02, 8'h02, 0, 8'h00, 0, 0, 0, 0);
    add(8'h00, 8'h02, 0, 8'h00, 0, 0, 0, 0);
    add(8'h02, 8'h02, 0, 8'h00, 0, 0, 0, 0);
    add(8'h02, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    add(8'h02, 8'h00, 0, 8'h02, 1, 1, 1, 1);
    add(8'h00, 8'h02, 0, 8'h02, 1, 1, 1, 1);

    do_reset();
    chk("reset_sticky", a_sticky, 0);
    chk("reset_irq", a_irq, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      err = tbl[i].err; mask = tbl[i].mask; clr = tbl[i].clr;
      step();
      $display("vec %0d err=%02h mask=%02h clr=%0d -> sticky=%02h count=%0d first=%0d valid=%0d irq=%0d",
               i, tbl[i].err, tbl[i].mask, tbl[i].clr, a_sticky, a_count, a_first, a_valid, a_irq);
      chk($sformatf("vec%0d_sticky", i), a_sticky, tbl[i].st);
      chk($sformatf("vec%0d_count", i), a_count, tbl[i].cnt);
      chk($sformatf("vec%0d_first", i), a_first, tbl[i].first);
      chk($sformatf("vec%0d_valid", i), a_valid, tbl[i].valid);
      chk($sformatf("vec%0d_irq", i), a_irq, tbl[i].irq);
      chk($sformatf("vec%0d_ovf", i), a_ovf, 0);
    end

    // ---- error line already high in the first cycle after reset release ----
    rstn = 1'b0; err = 8'h01; mask = '0; clr = 1'b0;
    step();
    #1;
    rstn = 1'b1;
    step();
    $display("post-reset high line: sticky=%02h count=%0d irq=%0d", a_sticky, a_count, a_irq);
    chk("postrst_count", a_count, 1);
    chk("postrst_sticky", a_sticky, 8'h01);
    chk("postrst_first", a_first, 0);
    chk("postrst_valid", a_valid, 1);

    // ---- saturation on the CNT_W=2 instance ----
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      err = 8'h01;
      step();
      $display("sat event %0d: b_count=%0d b_ovf=%0d a_count=%0d", i, b_count, b_ovf, a_count);
      chk($sformatf("sat%0d_count", i), b_count, (i > 3) ? 3 : i);
      chk($sformatf("sat%0d_ovf", i), b_ovf, (i > 3) ? 1 : 0);
      chk($sformatf("sat%0d_wide_count", i), a_count, i);
      err = 8'h00;
      step();
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    $display("sat clear: b_count=%0d b_ovf=%0d", b_count, b_ovf);
    chk("satclr_count", b_count, 0);
    chk("satclr_ovf", b_ovf, 0);

    // ---- asynchronous reset in the middle of ALARM ----
    err = 8'h10;
    step();
    chk("async_pre_irq", a_irq, 1);
    #2;
    rstn = 1'b0;
    #1;
    $display("async reset: irq=%0d sticky=%02h count=%0d valid=%0d", a_irq, a_sticky, a_count, a_valid);
    chk("async_irq", a_irq, 0);
    chk("async_sticky", a_sticky, 0);
    chk("async_count", a_count, 0);
    chk("async_valid", a_valid, 0);
    chk("async_b_count", b_count, 0);
    #1;
    rstn = 1'b1;
    err = 8'h00;

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      err  = 8'($urandom);
      mask = 8'($urandom & $urandom & $urandom);
      clr  = ($urandom_range(0, 11) == 0);
      model_step(err, mask, clr);
      step();
      chk("rnd_sticky", a_sticky, model_sticky());
      chk("rnd_count_a", a_count, m_cnt_a);
      chk("rnd_ovf_a", a_ovf, m_ovf_a);
      chk("rnd_first", a_first, m_first);
      chk("rnd_valid", a_valid, m_alarm);
      chk("rnd_irq", a_irq, m_alarm);
      chk("rnd_sticky_b", b_sticky, model_sticky());
      chk("rnd_count_b", b_count, m_cnt_b);
      chk("rnd_ovf_b", b_ovf, m_ovf_b);
      chk("rnd_irq_b", b_irq, m_alarm);
      if (i % 200 == 0)
        $display("rnd %0d err=%02h mask=%02h clr=%0d sticky=%02h cnt_a=%0d cnt_b=%0d irq=%0d",
                 i, err, mask, clr, a_sticky, a_count, b_count, a_irq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
